// File: rtl/conv_encoder_stream.sv
// Rate-1/N feed-forward convolutional encoder with valid/ready streaming,
// optional K-1 zero-bit frame termination and an out_last frame marker.
// With default parameters the coded bits match the K=3 (7,5) encoder.
module conv_encoder_stream #(
   parameter int unsigned    K       = 3,
   parameter int unsigned    N       = 2,
   parameter logic [N*K-1:0] GEN     = {3'b101, 3'b111},
   parameter bit             TAIL_EN = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_last
);

   localparam int unsigned CntW = $clog2(K + 1);

   typedef enum logic [0:0] {StRun, StTail} state_t;

   state_t          state_q, state_d;
   logic [K-2:0]    sr_q, sr_d;
   logic [CntW-1:0] tail_cnt_q, tail_cnt_d;
   logic            out_valid_q, out_valid_d;
   logic [N-1:0]    out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic            init_q;
   logic            slot_free;
   logic [K-1:0]    run_win;
   logic [K-1:0]    tail_win;

   // Coded bit i is the parity of the window masked by generator G_i.
   function automatic logic [N-1:0] encode(input logic [K-1:0] win);
      logic [N-1:0] enc;
      enc = '0;
      for (int i = 0; i < N; i++) begin
         enc[i] = ^(GEN[i*K +: K] & win);
      end
      return enc;
   endfunction

   // Window: bit 0 is the current input, bit j is sr[j-1] (sr[0] newest).
   assign run_win  = {sr_q, in_data};
   assign tail_win = {sr_q, 1'b0};

   assign slot_free = !out_valid_q || out_ready;
   // init_q holds in_ready low during reset and for the release cycle.
   assign in_ready  = init_q && (state_q == StRun) && slot_free;

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   // Next-state: output slot load/pop, shift register and tail sequencing.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      tail_cnt_d  = tail_cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         StRun: begin
            if (in_valid && in_ready) begin
               out_data_d  = encode(run_win);
               out_valid_d = 1'b1;
               out_last_d  = 1'b0;
               sr_d        = run_win[K-2:0];
               if (in_last) begin
                  if (TAIL_EN) begin
                     state_d    = StTail;
                     tail_cnt_d = CntW'(K - 1);
                  end else begin
                     // No tail: mark this word and restart from the zero state.
                     out_last_d = 1'b1;
                     sr_d       = '0;
                  end
               end
            end
         end
         StTail: begin
            if (slot_free) begin
               out_data_d  = encode(tail_win);
               out_valid_d = 1'b1;
               sr_d        = tail_win[K-2:0];
               tail_cnt_d  = tail_cnt_q - CntW'(1);
               out_last_d  = (tail_cnt_q == CntW'(1));
               if (tail_cnt_q == CntW'(1)) begin
                  state_d = StRun;
               end
            end
         end
      endcase
   end

   // State and output registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StRun;
         sr_q        <= '0;
         tail_cnt_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         init_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         tail_cnt_q  <= tail_cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         init_q      <= 1'b1;
      end
   end

endmodule
